// File: rtl/ic_periph_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ic_periph_arbiter_pkg : shared interconnect defaults and master IDs
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package ic_periph_arbiter_pkg;

  localparam int IC_ADDR_W = 32;
  localparam int IC_DATA_W = 32;

  typedef logic ic_mid_t;

  localparam ic_mid_t IC_MID_IMEM = 1'b0;
  localparam ic_mid_t IC_MID_DMEM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ic_id_fifo.sv
// ----------------------------------------------------------------------------
// ic_id_fifo : in-order FIFO of issuing master IDs, async active-high reset
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ic_id_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count   = r_count;
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && !o_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_do_push && !w_do_pop) begin
      r_count <= r_count + 1'b1;
    end else if (w_do_pop && !w_do_push) begin
      r_count <= r_count - 1'b1;
    end
  end

  generate
    if (DEPTH == 1) begin : g_single
      logic [W-1:0] r_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_do_push) begin
          r_data <= i_din;
        end
      end

      assign o_head = r_data;
    end else begin : g_multi
      localparam int PW = $clog2(DEPTH);

      // DEPTH is a power of two, so the pointers wrap naturally.
      logic [W-1:0]  r_mem [DEPTH];
      logic [PW-1:0] r_wptr;
      logic [PW-1:0] r_rptr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (w_do_push) r_wptr <= r_wptr + 1'b1;
          if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
      end

      assign o_head = r_mem[r_rptr];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ic_periph_arbiter.sv
// ----------------------------------------------------------------------------
// ic_periph_arbiter : round-robin 2-master arbiter with in-order response routing
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ic_periph_arbiter
  import ic_periph_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = IC_ADDR_W,
  parameter int DATA_W          = IC_DATA_W
) (
  input  logic                g_clk,
  input  logic                g_reset,
  input  logic                m0_req,
  output logic                m0_gnt,
  input  logic                m0_wen,
  input  logic [DATA_W/8-1:0] m0_strb,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_recv,
  input  logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_error,
  input  logic                m1_req,
  output logic                m1_gnt,
  input  logic                m1_wen,
  input  logic [DATA_W/8-1:0] m1_strb,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_recv,
  input  logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_error,
  output logic                s_req,
  input  logic                s_gnt,
  output logic                s_wen,
  output logic [DATA_W/8-1:0] s_strb,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_recv,
  output logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_error,
  output logic                orphan_rsp
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic    r_prio;
  logic    r_lock;
  ic_mid_t r_lock_id;
  logic    r_orphan;

  ic_mid_t       w_sel;
  ic_mid_t       w_head;
  logic          w_sel_req;
  logic          w_grant;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_head_ack;
  logic [CW-1:0] w_count;

  // A stalled request keeps the port until granted; otherwise round-robin on ties.
  always_comb begin
    w_sel = r_prio;
    if (r_lock) begin
      w_sel = r_lock_id;
    end else if (m0_req && !m1_req) begin
      w_sel = IC_MID_IMEM;
    end else if (m1_req && !m0_req) begin
      w_sel = IC_MID_DMEM;
    end
  end

  assign w_sel_req = (w_sel == IC_MID_DMEM) ? m1_req : m0_req;
  assign s_req     = !g_reset && w_sel_req && !w_full;
  assign w_grant   = s_req && s_gnt;
  assign m0_gnt    = w_grant && (w_sel == IC_MID_IMEM);
  assign m1_gnt    = w_grant && (w_sel == IC_MID_DMEM);

  assign s_wen   = (w_sel == IC_MID_DMEM) ? m1_wen   : m0_wen;
  assign s_strb  = (w_sel == IC_MID_DMEM) ? m1_strb  : m0_strb;
  assign s_addr  = (w_sel == IC_MID_DMEM) ? m1_addr  : m0_addr;
  assign s_wdata = (w_sel == IC_MID_DMEM) ? m1_wdata : m0_wdata;

  assign w_head_ack = (w_head == IC_MID_DMEM) ? m1_ack : m0_ack;
  assign s_ack      = !g_reset && !w_empty && w_head_ack;
  assign m0_recv    = !g_reset && s_recv && !w_empty && (w_head == IC_MID_IMEM);
  assign m1_recv    = !g_reset && s_recv && !w_empty && (w_head == IC_MID_DMEM);
  assign w_pop      = s_recv && s_ack;

  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_error   = s_error;
  assign m1_error   = s_error;
  assign orphan_rsp = r_orphan;

  ic_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (1)
  ) u_id_fifo (
    .clk     (g_clk),
    .rst     (g_reset),
    .i_push  (w_grant),
    .i_pop   (w_pop),
    .i_din   (w_sel),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_prio    <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= IC_MID_IMEM;
      r_orphan  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_prio <= !w_sel;
        r_lock <= 1'b0;
      end else if (s_req && !s_gnt) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end
      if (s_recv && (w_count == '0)) r_orphan <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ic_periph_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ic_periph_arbiter : directed self-checking bench for ic_periph_arbiter
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ic_periph_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;

  logic        clk = 1'b0;
  logic        g_reset;
  logic        m0_req, m0_gnt, m0_wen, m0_recv, m0_ack, m0_error;
  logic [3:0]  m0_strb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_gnt, m1_wen, m1_recv, m1_ack, m1_error;
  logic [3:0]  m1_strb;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_gnt, s_wen, s_recv, s_ack, s_error, orphan_rsp;
  logic [3:0]  s_strb;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ic_periph_arbiter #(.MAX_OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
    .g_clk(clk), .g_reset(g_reset),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_wen(m0_wen), .m0_strb(m0_strb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_recv(m0_recv), .m0_ack(m0_ack),
    .m0_rdata(m0_rdata), .m0_error(m0_error),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_wen(m1_wen), .m1_strb(m1_strb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_recv(m1_recv), .m1_ack(m1_ack),
    .m1_rdata(m1_rdata), .m1_error(m1_error),
    .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_recv(s_recv), .s_ack(s_ack),
    .s_rdata(s_rdata), .s_error(s_error), .orphan_rsp(orphan_rsp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    g_reset = 1'b1;
    m0_req = 0; m0_wen = 0; m0_strb = 4'hF; m0_addr = A0; m0_wdata = 32'h0; m0_ack = 0;
    m1_req = 0; m1_wen = 1; m1_strb = 4'h3; m1_addr = A1; m1_wdata = 32'h55; m1_ack = 0;
    s_gnt = 0; s_recv = 0; s_rdata = 0; s_error = 0;
    #2;
    m0_req = 1; m1_req = 1; s_gnt = 1; s_recv = 1; m0_ack = 1; m1_ack = 1;
    #1;
    chk("rst_s_req", s_req, 0);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_s_ack", s_ack, 0);
    chk("rst_orphan", orphan_rsp, 0);
    m0_req = 0; m1_req = 0; s_gnt = 0; s_recv = 0; m0_ack = 0; m1_ack = 0;
    tick(); tick();
    g_reset = 1'b0;

    // Alternating grants
    m0_req = 1; m1_req = 1; s_gnt = 1; #2;
    chk("alt0_m0_gnt", m0_gnt, 1); chk("alt0_m1_gnt", m1_gnt, 0); chk("alt0_addr", s_addr, A0);
    tick(); #2;
    chk("alt1_m1_gnt", m1_gnt, 1); chk("alt1_m0_gnt", m0_gnt, 0); chk("alt1_addr", s_addr, A1);
    chk("alt1_wen", s_wen, 1); chk("alt1_strb", s_strb, 4'h3);
    tick(); #2;
    chk("alt2_full_s_req", s_req, 0); chk("alt2_m0_gnt", m0_gnt, 0);

    // In-order routing, m0 stalls its ack for two cycles
    m0_req = 0; m1_req = 0; s_recv = 1; s_rdata = 32'hA; #1;
    chk("rsp0_m0_recv", m0_recv, 1); chk("rsp0_m1_recv", m1_recv, 0);
    chk("rsp0_s_ack", s_ack, 0); chk("rsp0_rdata", m0_rdata, 32'hA);
    tick(); #2;
    chk("rsp1_s_ack", s_ack, 0); chk("rsp1_m1_recv", m1_recv, 0);
    m0_ack = 1; #1;
    chk("rsp2_s_ack", s_ack, 1); chk("rsp2_m0_recv", m0_recv, 1);
    tick();
    m0_ack = 0; m1_ack = 1; s_rdata = 32'hB; s_error = 1; #2;
    chk("rsp3_m1_recv", m1_recv, 1); chk("rsp3_m0_recv", m0_recv, 0);
    chk("rsp3_s_ack", s_ack, 1); chk("rsp3_rdata", m1_rdata, 32'hB); chk("rsp3_err", m1_error, 1);
    tick();
    s_recv = 0; s_error = 0; m1_ack = 0;

    // Lock: m1 stalls, m0 joins and would win the tie (prio=0) without the lock
    m1_req = 1; s_gnt = 0; #2;
    chk("lk0_s_req", s_req, 1); chk("lk0_addr", s_addr, A1); chk("lk0_m1_gnt", m1_gnt, 0);
    tick();
    m0_req = 1; #2;
    chk("lk1_addr", s_addr, A1); chk("lk1_m0_gnt", m0_gnt, 0);
    tick(); #2;
    chk("lk2_addr", s_addr, A1);
    tick();
    s_gnt = 1; #2;
    chk("lk3_m1_gnt", m1_gnt, 1); chk("lk3_m0_gnt", m0_gnt, 0); chk("lk3_addr", s_addr, A1);
    tick();
    m1_req = 0; #2;
    chk("lk4_m0_gnt", m0_gnt, 1); chk("lk4_addr", s_addr, A0);
    tick();
    m0_req = 0; s_recv = 1; m1_ack = 1; #2;
    chk("lkr0_m1_recv", m1_recv, 1); chk("lkr0_s_ack", s_ack, 1);
    tick();
    m1_ack = 0; m0_ack = 1; #2;
    chk("lkr1_m0_recv", m0_recv, 1); chk("lkr1_s_ack", s_ack, 1);
    tick();
    s_recv = 0; m0_ack = 0;

    // Full plus pop
    m0_req = 1; #2;
    chk("fp0_m0_gnt", m0_gnt, 1);
    tick(); #2;
    chk("fp1_m0_gnt", m0_gnt, 1);
    tick();
    s_recv = 1; m0_ack = 1; #2;
    chk("fp2_s_req", s_req, 0); chk("fp2_m0_gnt", m0_gnt, 0); chk("fp2_s_ack", s_ack, 1);
    tick();
    s_recv = 0; #2;
    chk("fp3_m0_gnt", m0_gnt, 1);
    tick(); #2;
    chk("fp4_full", s_req, 0);
    m0_req = 0; s_recv = 1; #1;
    chk("fp5_s_ack", s_ack, 1);
    tick(); #2;
    chk("fp6_s_ack", s_ack, 1);
    tick();
    s_recv = 0; m0_ack = 0;

    // Orphan response
    s_recv = 1; m0_ack = 1; m1_ack = 1; #2;
    chk("orp_s_ack", s_ack, 0); chk("orp_m0_recv", m0_recv, 0); chk("orp_m1_recv", m1_recv, 0);
    tick();
    s_recv = 0; m0_ack = 0; m1_ack = 0; #2;
    chk("orp_set", orphan_rsp, 1);
    tick(); #2;
    chk("orp_sticky", orphan_rsp, 1);

    // Reset mid-operation with two outstanding
    m0_req = 1; #2;
    chk("rm0_m0_gnt", m0_gnt, 1);
    tick(); tick();
    m0_req = 0; m1_req = 1; s_recv = 1; m0_ack = 1; #2;
    chk("rm_pre_s_ack", s_ack, 1); chk("rm_pre_recv", m0_recv, 1);
    g_reset = 1'b1; #1;
    chk("rm_s_req", s_req, 0); chk("rm_s_ack", s_ack, 0); chk("rm_m0_recv", m0_recv, 0);
    chk("rm_m1_gnt", m1_gnt, 0); chk("rm_orphan", orphan_rsp, 0);
    tick();
    g_reset = 1'b0; s_recv = 0; m0_ack = 0; m0_req = 1; m1_req = 1; s_gnt = 1; #2;
    chk("post_m0_gnt", m0_gnt, 1); chk("post_m1_gnt", m1_gnt, 0);
    tick(); #2;
    chk("post_m1_gnt2", m1_gnt, 1);
    tick(); #2;
    chk("post_full", s_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
